adc_avg_filter: RTL and testbench

ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

---
 rtl/adc_pkg.sv | 34 +++
 rtl/adc_avg_ch.sv | 64 ++++++
 rtl/adc_avg_filter.sv | 75 +++++++
 tb/tb_adc_avg_filter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared widths, channel-mode encoding and alarm hysteresis rule for the ADC averaging filter.
// Pure definitions: no latency, no flow control.
package adc_pkg;

    localparam int ADC_W     = 8;
    localparam int AVG_DEPTH = 8;
    localparam int AVG_LOG2  = 3;
    localparam int SUM_W     = 11;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'b00,
        SEL_CH0  = 2'b01,
        SEL_CH1  = 2'b10,
        SEL_BOTH = 2'b11
    } sel_mode_e;

    // Between the two thresholds the previous alarm state is kept.
    function automatic logic alarm_next(
        input logic             cur,
        input logic [ADC_W-1:0] avg,
        input logic [ADC_W-1:0] hi_th,
        input logic [ADC_W-1:0] lo_th
    );
        if (avg >= hi_th) begin
            return 1'b1;
        end else if (avg <= lo_th) begin
            return 1'b0;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/adc_avg_ch.sv
// One channel: 8-deep boxcar average with hysteretic alarm; outputs register one cycle after acc.
// No backpressure: every acc is absorbed in the cycle it arrives.
module adc_avg_ch
    import adc_pkg::*;
#(
    parameter logic [ADC_W-1:0] HI_TH = 8'd200,
    parameter logic [ADC_W-1:0] LO_TH = 8'd180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] avg,
    output logic             valid,
    output logic             full,
    output logic             alarm
);

    logic [ADC_W-1:0]    mem [AVG_DEPTH];
    logic [AVG_LOG2-1:0] wp;
    logic [CNT_W-1:0]    fill;
    logic [SUM_W-1:0]    sum;

    logic [SUM_W-1:0]    sum_nxt;
    logic [CNT_W-1:0]    fill_nxt;
    logic [ADC_W-1:0]    avg_nxt;
    logic                win_full;

    // The slot being overwritten is still part of sum, so this never underflows.
    assign sum_nxt  = sum + SUM_W'(din) - SUM_W'(mem[wp]);
    assign fill_nxt = (fill == CNT_W'(AVG_DEPTH)) ? fill : fill + 1'b1;
    assign avg_nxt  = sum_nxt[SUM_W-1 -: ADC_W];
    assign win_full = (fill_nxt == CNT_W'(AVG_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp    <= '0;
            fill  <= '0;
            sum   <= '0;
            avg   <= '0;
            valid <= 1'b0;
            full  <= 1'b0;
            alarm <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (acc) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
                sum     <= sum_nxt;
                fill    <= fill_nxt;
                if (win_full) begin
                    avg   <= avg_nxt;
                    valid <= 1'b1;
                    full  <= 1'b1;
                    alarm <= alarm_next(alarm, avg_nxt, HI_TH, LO_TH);
                end
            end
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Two-channel ADC averaging filter: finish edge -> capture one cycle later -> averages visible two cycles after the edge.
// No backpressure: edges may arrive every second cycle and each is accepted.
module adc_avg_filter
    import adc_pkg::*;
#(
    parameter logic [ADC_W-1:0] HI_TH = 8'd200,
    parameter logic [ADC_W-1:0] LO_TH = 8'd180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             finish,
    input  logic [1:0]       sel,
    input  logic [ADC_W-1:0] data_CH0,
    input  logic [ADC_W-1:0] data_CH1,
    output logic [ADC_W-1:0] avg_CH0,
    output logic [ADC_W-1:0] avg_CH1,
    output logic             valid_CH0,
    output logic             valid_CH1,
    output logic             full_CH0,
    output logic             full_CH1,
    output logic             alarm_CH0,
    output logic             alarm_CH1
);

    logic      fin_d;
    logic      fin_blk;
    logic      pend;
    logic      fin_edge;
    logic      acc0;
    logic      acc1;
    sel_mode_e mode;

    // fin_blk remembers finish at the last reset edge so a level still high
    // when reset releases is not mistaken for a fresh conversion.
    assign fin_edge = finish & ~fin_d & ~fin_blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            fin_d   <= 1'b0;
            pend    <= 1'b0;
            fin_blk <= finish;
        end else begin
            fin_d   <= finish;
            pend    <= fin_edge;
            fin_blk <= 1'b0;
        end
    end

    assign mode = sel_mode_e'(sel);
    assign acc0 = pend & ((mode == SEL_CH0) || (mode == SEL_BOTH));
    assign acc1 = pend & ((mode == SEL_CH1) || (mode == SEL_BOTH));

    adc_avg_ch #(.HI_TH(HI_TH), .LO_TH(LO_TH)) u_ch0 (
        .clk   (clk),
        .rst   (rst),
        .acc   (acc0),
        .din   (data_CH0),
        .avg   (avg_CH0),
        .valid (valid_CH0),
        .full  (full_CH0),
        .alarm (alarm_CH0)
    );

    adc_avg_ch #(.HI_TH(HI_TH), .LO_TH(LO_TH)) u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .acc   (acc1),
        .din   (data_CH1),
        .avg   (avg_CH1),
        .valid (valid_CH1),
        .full  (full_CH1),
        .alarm (alarm_CH1)
    );

endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter: directed scenarios plus random traffic against a queue-based reference.
module tb_adc_avg_filter;

    localparam int HI = 200;
    localparam int LO = 180;

    logic       clk = 1'b0;
    logic       rst;
    logic       finish;
    logic [1:0] sel;
    logic [7:0] data_CH0, data_CH1;
    logic [7:0] avg_CH0, avg_CH1;
    logic       valid_CH0, valid_CH1;
    logic       full_CH0, full_CH1;
    logic       alarm_CH0, alarm_CH1;

    always #5 clk = ~clk;

    adc_avg_filter #(.HI_TH(8'd200), .LO_TH(8'd180)) dut (
        .clk       (clk),
        .rst       (rst),
        .finish    (finish),
        .sel       (sel),
        .data_CH0  (data_CH0),
        .data_CH1  (data_CH1),
        .avg_CH0   (avg_CH0),
        .avg_CH1   (avg_CH1),
        .valid_CH0 (valid_CH0),
        .valid_CH1 (valid_CH1),
        .full_CH0  (full_CH0),
        .full_CH1  (full_CH1),
        .alarm_CH0 (alarm_CH0),
        .alarm_CH1 (alarm_CH1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: history of accepted samples per channel, newest at the back.
    int q0[$];
    int q1[$];
    int acc_cnt [2];
    int exp_avg [2];
    bit exp_valid [2];
    bit exp_full [2];
    bit exp_alarm [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int win_sum(input int ch);
        int s = 0;
        if (ch == 0) begin
            foreach (q0[i]) s += q0[i];
        end else begin
            foreach (q1[i]) s += q1[i];
        end
        return s;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int ch = 0; ch < 2; ch++) begin
            acc_cnt[ch]   = 0;
            exp_avg[ch]   = 0;
            exp_valid[ch] = 1'b0;
            exp_full[ch]  = 1'b0;
            exp_alarm[ch] = 1'b0;
        end
    endtask

    task automatic model_accept(input int ch, input int d);
        if (ch == 0) begin
            q0.push_back(d);
            if (q0.size() > 8) void'(q0.pop_front());
        end else begin
            q1.push_back(d);
            if (q1.size() > 8) void'(q1.pop_front());
        end
        acc_cnt[ch]++;
        if (acc_cnt[ch] >= 8) begin
            exp_avg[ch]   = win_sum(ch) / 8;
            exp_valid[ch] = 1'b1;
            exp_full[ch]  = 1'b1;
            if (exp_avg[ch] >= HI)      exp_alarm[ch] = 1'b1;
            else if (exp_avg[ch] <= LO) exp_alarm[ch] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid0"}, valid_CH0, exp_valid[0]);
        chk({tag, ".avg0"},   avg_CH0,   exp_avg[0]);
        chk({tag, ".full0"},  full_CH0,  exp_full[0]);
        chk({tag, ".alarm0"}, alarm_CH0, exp_alarm[0]);
        chk({tag, ".valid1"}, valid_CH1, exp_valid[1]);
        chk({tag, ".avg1"},   avg_CH1,   exp_avg[1]);
        chk({tag, ".full1"},  full_CH1,  exp_full[1]);
        chk({tag, ".alarm1"}, alarm_CH1, exp_alarm[1]);
        chk({tag, ".fill0"},  dut.u_ch0.fill, (acc_cnt[0] > 8) ? 8 : acc_cnt[0]);
        chk({tag, ".fill1"},  dut.u_ch1.fill, (acc_cnt[1] > 8) ? 8 : acc_cnt[1]);
        chk({tag, ".wp0"},    dut.u_ch0.wp,   acc_cnt[0] % 8);
        chk({tag, ".wp1"},    dut.u_ch1.wp,   acc_cnt[1] % 8);
    endtask

    // One conversion: finish high for 'hold' cycles starting in cycle E; checks every cycle up to at least E+3.
    task automatic send(input int d0, input int d1, input logic [1:0] s, input int hold, input string tag);
        int n;
        n = (hold > 3) ? hold : 3;
        @(posedge clk); #1;
        finish   = 1'b1;
        data_CH0 = 8'(d0);
        data_CH1 = 8'(d1);
        sel      = s;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == hold) finish = 1'b0;
            exp_valid[0] = 1'b0;
            exp_valid[1] = 1'b0;
            if (c == 2) begin
                if (s[0]) model_accept(0, d0);
                if (s[1]) model_accept(1, d1);
            end
            @(negedge clk);
            check_all(tag);
        end
    endtask

    // Two edges two cycles apart; the second must not be lost.
    task automatic send_b2b(input int a0, input int a1, input int b0, input int b1);
        @(posedge clk); #1;
        finish = 1'b1; data_CH0 = 8'(a0); data_CH1 = 8'(a1); sel = 2'b11;
        @(posedge clk); #1;
        finish = 1'b0;
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
        @(negedge clk); check_all("b2b_e1");
        @(posedge clk); #1;
        finish = 1'b1; data_CH0 = 8'(b0); data_CH1 = 8'(b1);
        model_accept(0, a0); model_accept(1, a1);
        @(negedge clk); check_all("b2b_e2");
        @(posedge clk); #1;
        finish = 1'b0;
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
        @(negedge clk); check_all("b2b_e3");
        @(posedge clk); #1;
        model_accept(0, b0); model_accept(1, b1);
        @(negedge clk); check_all("b2b_e4");
        @(posedge clk); #1;
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
        @(negedge clk); check_all("b2b_e5");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; finish = 1'b0; sel = 2'b00; data_CH0 = 8'd0; data_CH1 = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");

        // finish rises during reset and is still high when reset releases
        @(posedge clk); #1;
        finish = 1'b1; sel = 2'b11;
        data_CH0 = 8'($urandom_range(0, 255)); data_CH1 = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_all("rst_fin_high");
        end
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        check_all("rst_fin_low");

        // fill channel 0 only
        for (int i = 0; i < 8; i++) send(100, $urandom_range(0, 255), 2'b01, 1, "fill");
        chk("fill_avg0", avg_CH0, 100);
        chk("fill_full0", full_CH0, 1);
        chk("fill_full1", full_CH1, 0);

        // wrap and alarm set
        send(200, 0, 2'b01, 2, "wrap1");
        chk("wrap_avg112", avg_CH0, 112);
        for (int i = 0; i < 7; i++) send(200, 0, 2'b01, 1, "wrap");
        chk("wrap_avg200", avg_CH0, 200);
        chk("wrap_wp0", dut.u_ch0.wp, 0);
        chk("hyst_set200", alarm_CH0, 1);

        // hysteresis
        send(120, 0, 2'b01, 1, "hyst190");
        chk("hyst_avg190", avg_CH0, 190);
        chk("hyst_hold190", alarm_CH0, 1);
        send(120, 0, 2'b01, 1, "hyst180");
        chk("hyst_avg180", avg_CH0, 180);
        chk("hyst_clr180", alarm_CH0, 0);
        send(255, 0, 2'b01, 1, "hyst_a");
        send(255, 0, 2'b01, 1, "hyst_b");
        send(248, 0, 2'b01, 1, "hyst199");
        chk("hyst_avg199", avg_CH0, 199);
        chk("hyst_hold199", alarm_CH0, 0);

        // long finish pulse counts once
        send($urandom_range(0, 255), $urandom_range(0, 255), 2'b11, 5, "hold5");
        chk("hold5_fill1", dut.u_ch1.fill, 1);

        // idle mode
        for (int i = 0; i < 4; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 2'b00, 1, "idle");

        // both channels
        for (int i = 0; i < 10; i++)
            send($urandom_range(0, 255), $urandom_range(0, 255), 2'b11, $urandom_range(1, 3), "both");

        send_b2b($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        send_b2b($urandom_range(150, 255), $urandom_range(0, 80), $urandom_range(150, 255), $urandom_range(0, 80));

        // random mixed traffic
        for (int i = 0; i < 20; i++)
            send($urandom_range(0, 255), $urandom_range(0, 255), 2'($urandom_range(0, 3)), $urandom_range(1, 4), "rand");

        // reset after 5 accepted samples
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        @(negedge clk); check_all("rst_a");
        for (int i = 0; i < 5; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 2'b11, 1, "mid5");
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        @(negedge clk); check_all("rst_mid5");
        chk("rst_mid5_full0", full_CH0, 0);

        // reset one cycle after an edge discards the pending sample
        @(posedge clk); #1;
        finish = 1'b1; sel = 2'b11; data_CH0 = 8'd77; data_CH1 = 8'd88;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; finish = 1'b0;
        model_reset();
        @(negedge clk); check_all("rst_pend");
        repeat (2) begin @(posedge clk); #1; @(negedge clk); check_all("rst_pend_after"); end

        for (int i = 0; i < 7; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 2'b11, 1, "refill");
        chk("refill7_full0", full_CH0, 0);
        chk("refill7_full1", full_CH1, 0);
        send($urandom_range(0, 255), $urandom_range(0, 255), 2'b11, 1, "refill8");
        chk("refill8_full0", full_CH0, 1);
        chk("refill8_full1", full_CH1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
